pc_unit: RTL and testbench

Parametrised program-counter unit for the fetch stage of the RISC-V core. It holds the fetch address and advances it sequentially when the instruction memory accepts a fetch. It also handles stall, branch/jump redirect, trap entry, misaligned-target detection and a debug halt/resume state machine. Its output drives the instruction-memory address and the IF/ID pipeline register.

---
 rtl/pc_unit.sv | 152 +++++++++++++++
 tb/tb_pc_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter.
// Holds the current fetch address and advances it when instruction memory
// accepts a fetch. Handles stall, branch/jump redirect with alignment check,
// trap entry, and a debug halt/resume state machine.
//
// States:
//   state | meaning
//   BOOT  | just out of reset, pc = RESET_VEC, no fetch issued yet
//   RUN   | live fetch: pc_valid = 1, pc advances / redirects
//   HALT  | debug halt: pc_valid = 0, pc frozen except redirect/trap
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous reset, active-high
//   stall          hold pc (hazard)
//   if_ready       instruction memory accepted the current fetch
//   redirect_valid branch/jump taken, target on redirect_addr
//   redirect_addr  branch/jump target
//   trap           exception/interrupt entry
//   halt_req       debug halt request
//   resume         debug resume request
//   pc             current fetch address (registered)
//   pc_valid       pc is a live fetch request
//   pc_seq         pc + STEP, wraps modulo 2^XLEN
//   misalign_err   one-cycle pulse after a rejected misaligned redirect
//   bad_addr       last rejected redirect target
//   halted         unit is in HALT
module pc_unit #(
    parameter int               XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_VEC = 32'h0000_0000,
    parameter logic [XLEN-1:0]  TRAP_VEC  = 32'h0000_0100,
    parameter int               STEP      = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            if_ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_addr,
    input  logic            trap,
    input  logic            halt_req,
    input  logic            resume,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    output logic [XLEN-1:0] pc_seq,
    output logic            misalign_err,
    output logic [XLEN-1:0] bad_addr,
    output logic            halted
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    // STEP is 2 or 4, so the alignment test reduces to a low-bit mask.
    localparam logic [XLEN-1:0] STEP_INC   = XLEN'(STEP);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(STEP - 1);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            misalign_q, misalign_d;
    logic [XLEN-1:0] bad_addr_q, bad_addr_d;

    logic            redir_misaligned;
    logic [XLEN-1:0] redir_target;

    // Sequential next address; wraps naturally in XLEN bits.
    assign pc_seq = pc_q + STEP_INC;

    // A misaligned target is not followed; it is turned into a trap-vector
    // jump so the core lands in its exception handler.
    assign redir_misaligned = |(redirect_addr & ALIGN_MASK);
    assign redir_target     = redir_misaligned ? TRAP_VEC : redirect_addr;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        misalign_d = 1'b0;
        bad_addr_d = bad_addr_q;

        unique case (state_q)
            ST_BOOT: begin
                // First fetch goes out from RESET_VEC one cycle after release.
                state_d = ST_RUN;
            end

            ST_RUN: begin
                // Flushes (trap, redirect) beat halt and stall. A halt that
                // coincides with a flush waits for the next edge.
                if (trap) begin
                    pc_d = TRAP_VEC;
                end else if (redirect_valid) begin
                    pc_d = redir_target;
                    if (redir_misaligned) begin
                        misalign_d = 1'b1;
                        bad_addr_d = redirect_addr;
                    end
                end else if (halt_req) begin
                    state_d = ST_HALT;
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (if_ready) begin
                    pc_d = pc_seq;
                end
            end

            ST_HALT: begin
                // if_ready is ignored: no fetch is outstanding while halted.
                if (trap) begin
                    state_d = ST_RUN;
                    pc_d    = TRAP_VEC;
                end else if (redirect_valid) begin
                    pc_d = redir_target;
                    if (redir_misaligned) begin
                        misalign_d = 1'b1;
                        bad_addr_d = redirect_addr;
                    end
                end else if (resume && !halt_req) begin
                    state_d = ST_RUN;
                end
            end

            default: begin
                state_d = ST_BOOT;
                pc_d    = RESET_VEC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_VEC;
            misalign_q <= 1'b0;
            bad_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
            bad_addr_q <= bad_addr_d;
        end
    end

    assign pc           = pc_q;
    assign pc_valid     = (state_q == ST_RUN);
    assign halted       = (state_q == ST_HALT);
    assign misalign_err = misalign_q;
    assign bad_addr     = bad_addr_q;

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        if_ready;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        trap;
    logic        halt_req;
    logic        resume;

    logic [31:0] pc, pc_seq, bad_addr;
    logic        pc_valid, misalign_err, halted;

    logic [31:0] pc2, pc_seq2, bad_addr2;
    logic        pc_valid2, misalign_err2, halted2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pc_unit #(.XLEN(32), .RESET_VEC(32'h0), .TRAP_VEC(32'h100), .STEP(4)) u_dut (
        .clk(clk), .rst(rst), .stall(stall), .if_ready(if_ready),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .trap(trap), .halt_req(halt_req), .resume(resume),
        .pc(pc), .pc_valid(pc_valid), .pc_seq(pc_seq),
        .misalign_err(misalign_err), .bad_addr(bad_addr), .halted(halted)
    );

    // Second instance with STEP=2 shares the inputs; only checked where the
    // alignment rule makes the two diverge.
    pc_unit #(.XLEN(32), .RESET_VEC(32'h0), .TRAP_VEC(32'h100), .STEP(2)) u_dut2 (
        .clk(clk), .rst(rst), .stall(stall), .if_ready(if_ready),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .trap(trap), .halt_req(halt_req), .resume(resume),
        .pc(pc2), .pc_valid(pc_valid2), .pc_seq(pc_seq2),
        .misalign_err(misalign_err2), .bad_addr(bad_addr2), .halted(halted2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; if_ready = 1'b0; redirect_valid = 1'b0;
        redirect_addr = 32'h0; trap = 1'b0; halt_req = 1'b0; resume = 1'b0;
        repeat (3) tick();
        n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
        n_cmp++; if (pc_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", pc_valid); end
        n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted got=%b exp=0", halted); end
        n_cmp++; if (misalign_err !== 1'b0) begin n_err++; $display("FAIL reset_misalign got=%b exp=0", misalign_err); end
        n_cmp++; if (bad_addr !== 32'h0) begin n_err++; $display("FAIL reset_bad_addr got=%h exp=0", bad_addr); end
        n_cmp++; if (pc_seq !== 32'h4) begin n_err++; $display("FAIL reset_pc_seq got=%h exp=4", pc_seq); end
    endtask

    task automatic test_boot_step();
        rst = 1'b0; if_ready = 1'b1;
        tick();
        n_cmp++; if (pc_valid !== 1'b1) begin n_err++; $display("FAIL boot_valid got=%b exp=1", pc_valid); end
        n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL boot_pc got=%h exp=0", pc); end
        tick();
        n_cmp++; if (pc !== 32'h4) begin n_err++; $display("FAIL step1_pc got=%h exp=4", pc); end
        tick();
        n_cmp++; if (pc !== 32'h8) begin n_err++; $display("FAIL step2_pc got=%h exp=8", pc); end
        tick();
        n_cmp++; if (pc !== 32'hC) begin n_err++; $display("FAIL step3_pc got=%h exp=c", pc); end
        if_ready = 1'b0;
        tick();
        n_cmp++; if (pc !== 32'hC) begin n_err++; $display("FAIL hold_no_ready got=%h exp=c", pc); end
    endtask

    task automatic test_stall_redirect();
        if_ready = 1'b1;
        tick();
        n_cmp++; if (pc !== 32'h10) begin n_err++; $display("FAIL pre_stall_pc got=%h exp=10", pc); end
        stall = 1'b1;
        tick();
        n_cmp++; if (pc !== 32'h10) begin n_err++; $display("FAIL stall1_pc got=%h exp=10", pc); end
        tick();
        n_cmp++; if (pc !== 32'h10) begin n_err++; $display("FAIL stall2_pc got=%h exp=10", pc); end
        redirect_valid = 1'b1; redirect_addr = 32'h0;
        tick();
        n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL stall_redirect_zero got=%h exp=0", pc); end
        n_cmp++; if (misalign_err !== 1'b0) begin n_err++; $display("FAIL stall_redirect_misalign got=%b exp=0", misalign_err); end
        stall = 1'b0; redirect_valid = 1'b0; if_ready = 1'b0;
    endtask

    task automatic test_misalign();
        redirect_valid = 1'b1; redirect_addr = 32'h22;
        tick();
        redirect_valid = 1'b0;
        n_cmp++; if (pc !== 32'h100) begin n_err++; $display("FAIL misalign_pc got=%h exp=100", pc); end
        n_cmp++; if (misalign_err !== 1'b1) begin n_err++; $display("FAIL misalign_pulse got=%b exp=1", misalign_err); end
        n_cmp++; if (bad_addr !== 32'h22) begin n_err++; $display("FAIL misalign_bad_addr got=%h exp=22", bad_addr); end
        n_cmp++; if (pc2 !== 32'h22) begin n_err++; $display("FAIL step2_aligned_pc got=%h exp=22", pc2); end
        n_cmp++; if (misalign_err2 !== 1'b0) begin n_err++; $display("FAIL step2_no_err got=%b exp=0", misalign_err2); end
        n_cmp++; if (bad_addr2 !== 32'h0) begin n_err++; $display("FAIL step2_bad_addr got=%h exp=0", bad_addr2); end
        tick();
        n_cmp++; if (misalign_err !== 1'b0) begin n_err++; $display("FAIL misalign_one_cycle got=%b exp=0", misalign_err); end
        n_cmp++; if (bad_addr !== 32'h22) begin n_err++; $display("FAIL bad_addr_hold got=%h exp=22", bad_addr); end
        n_cmp++; if (pc !== 32'h100) begin n_err++; $display("FAIL misalign_pc_hold got=%h exp=100", pc); end
    endtask

    task automatic test_trap_priority();
        redirect_valid = 1'b1; redirect_addr = 32'h50;
        tick();
        n_cmp++; if (pc !== 32'h50) begin n_err++; $display("FAIL redirect_50 got=%h exp=50", pc); end
        trap = 1'b1; redirect_addr = 32'h40; stall = 1'b1;
        tick();
        trap = 1'b0; redirect_valid = 1'b0; stall = 1'b0;
        n_cmp++; if (pc !== 32'h100) begin n_err++; $display("FAIL trap_over_redirect got=%h exp=100", pc); end
        n_cmp++; if (misalign_err !== 1'b0) begin n_err++; $display("FAIL trap_no_misalign got=%b exp=0", misalign_err); end
    endtask

    task automatic test_halt_resume();
        redirect_valid = 1'b1; redirect_addr = 32'h30;
        tick();
        redirect_valid = 1'b0;
        n_cmp++; if (pc !== 32'h30) begin n_err++; $display("FAIL redirect_30 got=%h exp=30", pc); end
        halt_req = 1'b1; if_ready = 1'b1;
        tick();
        halt_req = 1'b0;
        n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL halt_enter got=%b exp=1", halted); end
        n_cmp++; if (pc_valid !== 1'b0) begin n_err++; $display("FAIL halt_valid got=%b exp=0", pc_valid); end
        n_cmp++; if (pc !== 32'h30) begin n_err++; $display("FAIL halt_pc got=%h exp=30", pc); end
        tick(); tick();
        n_cmp++; if (pc !== 32'h30) begin n_err++; $display("FAIL halt_frozen got=%h exp=30", pc); end
        redirect_valid = 1'b1; redirect_addr = 32'h80;
        tick();
        redirect_valid = 1'b0;
        n_cmp++; if (pc !== 32'h80) begin n_err++; $display("FAIL halt_redirect_pc got=%h exp=80", pc); end
        n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL halt_redirect_stay got=%b exp=1", halted); end
        halt_req = 1'b1; resume = 1'b1;
        tick();
        halt_req = 1'b0;
        n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL halt_and_resume_stay got=%b exp=1", halted); end
        tick();
        resume = 1'b0;
        n_cmp++; if (pc_valid !== 1'b1) begin n_err++; $display("FAIL resume_valid got=%b exp=1", pc_valid); end
        n_cmp++; if (pc !== 32'h80) begin n_err++; $display("FAIL resume_pc got=%h exp=80", pc); end
        n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL resume_halted got=%b exp=0", halted); end
        tick();
        n_cmp++; if (pc !== 32'h84) begin n_err++; $display("FAIL resume_step got=%h exp=84", pc); end
    endtask

    task automatic test_halt_collision();
        halt_req = 1'b1; trap = 1'b1;
        tick();
        trap = 1'b0;
        n_cmp++; if (pc !== 32'h100) begin n_err++; $display("FAIL halt_trap_pc got=%h exp=100", pc); end
        n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL halt_trap_deferred got=%b exp=0", halted); end
        tick();
        halt_req = 1'b0;
        n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL halt_after_trap got=%b exp=1", halted); end
        n_cmp++; if (pc !== 32'h100) begin n_err++; $display("FAIL halt_after_trap_pc got=%h exp=100", pc); end
        trap = 1'b1;
        tick();
        trap = 1'b0;
        n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL halt_trap_exit got=%b exp=0", halted); end
        n_cmp++; if (pc_valid !== 1'b1) begin n_err++; $display("FAIL halt_trap_exit_valid got=%b exp=1", pc_valid); end
    endtask

    task automatic test_wrap_reset();
        redirect_valid = 1'b1; redirect_addr = 32'hFFFF_FFFC; if_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        n_cmp++; if (pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_setup got=%h exp=fffffffc", pc); end
        n_cmp++; if (pc_seq !== 32'h0) begin n_err++; $display("FAIL wrap_pc_seq got=%h exp=0", pc_seq); end
        tick();
        n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL wrap_pc got=%h exp=0", pc); end
        tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL pre_reset_halt got=%b exp=1", halted); end
        rst = 1'b1;
        tick();
        n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL midreset_halted got=%b exp=0", halted); end
        n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL midreset_pc got=%h exp=0", pc); end
        n_cmp++; if (pc_valid !== 1'b0) begin n_err++; $display("FAIL midreset_valid got=%b exp=0", pc_valid); end
        n_cmp++; if (bad_addr !== 32'h0) begin n_err++; $display("FAIL midreset_bad_addr got=%h exp=0", bad_addr); end
        rst = 1'b0;
        tick();
        n_cmp++; if (pc_valid !== 1'b1) begin n_err++; $display("FAIL reboot_valid got=%b exp=1", pc_valid); end
        n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL reboot_pc got=%h exp=0", pc); end
    endtask

    initial begin
        test_reset();
        test_boot_step();
        test_stall_redirect();
        test_misalign();
        test_trap_priority();
        test_halt_resume();
        test_halt_collision();
        test_wrap_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
